// File: rtl/multicycle_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer_pkg
// Shared definitions for the multicycle instruction sequencer:
//   - seq_state_t : FSM state encoding (also visible on the STATE debug port)
//   - OP_*        : opcode constants of the supported instruction classes
//   - FUNCT3_LOAD : funct3 value that turns an OP_IALU instruction into a load
//   - is_legal_op : opcode legality check used by the decode step
// No ports; imported by multicycle_sequencer and seq_wait_timer.
// ----------------------------------------------------------------------------
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } seq_state_t;

   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [2:0] FUNCT3_LOAD = 3'b010;

   // True for every opcode the sequencer knows how to step through.
   function automatic logic is_legal_op(input logic [6:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_IALU, OP_R, OP_S, OP_LUI, OP_B, OP_JAL, OP_JALR: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// ----------------------------------------------------------------------------
// seq_wait_timer
// Counts cycles spent waiting for a memory acknowledge and flags a timeout
// on the last permitted wait cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   waiting    : sequencer is in a state that waits for an ack (FETCH or MEM)
//   ack        : the ack relevant to the current waiting state
//   timeout    : this cycle is wait cycle number MEM_TIMEOUT and no ack came
// Parameter MEM_TIMEOUT (1..255): number of wait cycles allowed.
// ----------------------------------------------------------------------------
module seq_wait_timer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic ack,
   output logic timeout
);

   // The counter holds the number of ack-less cycles already spent, so the
   // current cycle is wait cycle count+1; the last allowed one is count==MEM_TIMEOUT-1.
   localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count;

   // Holding the counter at zero outside the waiting states makes every entry
   // into FETCH or MEM start from a clean count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (!waiting || ack) begin
         count <= 8'd0;
      end else if (count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   // An ack in the final wait cycle wins over the timeout.
   assign timeout = waiting && !ack && (count >= LAST_WAIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer
// Control FSM of a multicycle processor: IDLE -> FETCH -> DECODE -> EXEC
// -> [MEM] -> WB, with a sticky TRAP for illegal opcodes and ack timeouts.
// Ports:
//   CLK, RST_N         : clock, asynchronous active-low reset
//   EN                 : run enable, sampled only in IDLE and WB
//   OP_CODE, FUNCT_3   : fields of the instruction register
//   IM_ACK, DM_ACK     : single-cycle memory acknowledges
//   IM_REQ, DM_REQ     : memory requests (registered)
//   DM_WE              : data write qualifier (registered)
//   IR_WE              : instruction register load, in the IM_ACK cycle
//   RF_WE, PC_WE       : write-back strobes (registered)
//   ERR                : sticky trap flag (registered)
//   STATE              : current state encoding
//   CYC_CNT, RET_CNT   : performance counters, only with SEQ_PERF_CNT_EN
// Optional feature macro: SEQ_PERF_CNT_EN
// ----------------------------------------------------------------------------
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EN,
   input  logic [6:0]  OP_CODE,
   input  logic [2:0]  FUNCT_3,
   input  logic        IM_ACK,
   input  logic        DM_ACK,
   output logic        IM_REQ,
   output logic        DM_REQ,
   output logic        DM_WE,
   output logic        IR_WE,
   output logic        RF_WE,
   output logic        PC_WE,
   output logic        ERR,
   output logic [2:0]  STATE
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] CYC_CNT,
   output logic [31:0] RET_CNT
`endif
);

   seq_state_t state;
   seq_state_t state_nxt;

   logic waiting;
   logic ack;
   logic timeout;

   // Instruction class, captured in DECODE so later steps do not depend on
   // the instruction register staying stable.
   logic mem_op;
   logic store_op;
   logic rf_write;

   assign waiting = (state == ST_FETCH) || (state == ST_MEM);
   assign ack     = ((state == ST_FETCH) && IM_ACK) || ((state == ST_MEM) && DM_ACK);

   seq_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (CLK),
      .rst_n   (RST_N),
      .waiting (waiting),
      .ack     (ack),
      .timeout (timeout)
   );

   // Next-state selection; acks are only looked at in their own waiting state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (EN) state_nxt = ST_FETCH;
         ST_FETCH:  begin
            if (IM_ACK)       state_nxt = ST_DECODE;
            else if (timeout) state_nxt = ST_TRAP;
         end
         ST_DECODE: state_nxt = is_legal_op(OP_CODE) ? ST_EXEC : ST_TRAP;
         ST_EXEC:   state_nxt = mem_op ? ST_MEM : ST_WB;
         ST_MEM:    begin
            if (DM_ACK)       state_nxt = ST_WB;
            else if (timeout) state_nxt = ST_TRAP;
         end
         ST_WB:     state_nxt = EN ? ST_FETCH : ST_IDLE;
         default:   state_nxt = ST_TRAP;
      endcase
   end

   // State register plus outputs registered from the state being entered, so
   // no ack can reach a request output combinationally.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         mem_op   <= 1'b0;
         store_op <= 1'b0;
         rf_write <= 1'b0;
         IM_REQ   <= 1'b0;
         DM_REQ   <= 1'b0;
         DM_WE    <= 1'b0;
         RF_WE    <= 1'b0;
         PC_WE    <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_DECODE) begin
            store_op <= (OP_CODE == OP_S);
            mem_op   <= (OP_CODE == OP_S) ||
                        ((OP_CODE == OP_IALU) && (FUNCT_3 == FUNCT3_LOAD));
            rf_write <= (OP_CODE != OP_S) && (OP_CODE != OP_B);
         end
         IM_REQ <= (state_nxt == ST_FETCH);
         DM_REQ <= (state_nxt == ST_MEM);
         DM_WE  <= (state_nxt == ST_MEM) && store_op;
         RF_WE  <= (state_nxt == ST_WB) && rf_write;
         PC_WE  <= (state_nxt == ST_WB);
         ERR    <= (state_nxt == ST_TRAP);
      end
   end

   // The instruction register must load in the very cycle its data is valid.
   assign IR_WE = (state == ST_FETCH) && IM_ACK;
   assign STATE = state;

`ifdef SEQ_PERF_CNT_EN
   // Busy cycles and retired instructions; both wrap naturally at 2^32.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CYC_CNT <= 32'd0;
         RET_CNT <= 32'd0;
      end else begin
         if ((state != ST_IDLE) && (state != ST_TRAP)) CYC_CNT <= CYC_CNT + 32'd1;
         if (state == ST_WB)                           RET_CNT <= RET_CNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Self-checking bench: instructions are described at transaction level
// (class, ack delays, EN at write-back) and expanded into an expected
// per-cycle trace of state and strobes, which is then played against the DUT.
// Build with SEQ_PERF_CNT_EN defined to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_multicycle_sequencer;

   localparam int T = 4;

   localparam logic [6:0] I_ALU  = 7'b0010011;
   localparam logic [6:0] R_ALU  = 7'b0110011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef struct {
      int         en;
      logic [6:0] op;
      logic [2:0] f3;
      int         im_ack;
      int         dm_ack;
      logic [9:0] expect_v;
   } cycle_t;

   logic        CLK;
   logic        RST_N;
   logic        EN;
   logic [6:0]  OP_CODE;
   logic [2:0]  FUNCT_3;
   logic        IM_ACK;
   logic        DM_ACK;
   logic        IM_REQ;
   logic        DM_REQ;
   logic        DM_WE;
   logic        IR_WE;
   logic        RF_WE;
   logic        PC_WE;
   logic        ERR;
   logic [2:0]  STATE;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] CYC_CNT;
   logic [31:0] RET_CNT;
`endif

   logic [9:0]  observed;
   cycle_t      plan[$];
   int          checks = 0;
   int          errors = 0;
   bit          atIdle;
   bit          trapped;
   string       section;

   multicycle_sequencer #(
      .MEM_TIMEOUT (T)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .EN      (EN),
      .OP_CODE (OP_CODE),
      .FUNCT_3 (FUNCT_3),
      .IM_ACK  (IM_ACK),
      .DM_ACK  (DM_ACK),
      .IM_REQ  (IM_REQ),
      .DM_REQ  (DM_REQ),
      .DM_WE   (DM_WE),
      .IR_WE   (IR_WE),
      .RF_WE   (RF_WE),
      .PC_WE   (PC_WE),
      .ERR     (ERR),
      .STATE   (STATE)
`ifdef SEQ_PERF_CNT_EN
      ,
      .CYC_CNT (CYC_CNT),
      .RET_CNT (RET_CNT)
`endif
   );

   assign observed = {STATE, IM_REQ, DM_REQ, DM_WE, IR_WE, RF_WE, PC_WE, ERR};

   // Free-running clock, period 10.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Packs the expected state and strobes in the same order as 'observed'.
   function automatic logic [9:0] expOut(input int st, input int imr, input int dmr,
                                         input int dmw, input int irw, input int rfw,
                                         input int pcw, input int err);
      return {3'(st), 1'(imr), 1'(dmr), 1'(dmw), 1'(irw), 1'(rfw), 1'(pcw), 1'(err)};
   endfunction

   function automatic int rnd();
      return int'($urandom_range(0, 1));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic pushCycle(input int en, input logic [6:0] op, input logic [2:0] f3,
                            input int ia, input int da, input logic [9:0] e);
      cycle_t c;
      c.en = en; c.op = op; c.f3 = f3; c.im_ack = ia; c.dm_ack = da; c.expect_v = e;
      plan.push_back(c);
   endtask

   task automatic addTrap(input int n);
      for (int i = 0; i < n; i++)
         pushCycle(rnd(), 7'($urandom), 3'($urandom), rnd(), rnd(), expOut(6, 0, 0, 0, 0, 0, 0, 1));
   endtask

   // Expands one instruction into its expected cycle trace. Delays count the
   // ack-less cycles before the ack; a delay of T or more means the ack never
   // comes within the allowed window.
   task automatic addInstr(input logic [6:0] op, input logic [2:0] f3, input int imDelay,
                           input int dmDelay, input int enWb, output bit trap);
      bit legal, isStore, isLoad, isBranch;
      legal    = op inside {I_ALU, R_ALU, STORE, LUI, BRANCH, JAL, JALR};
      isStore  = (op == STORE);
      isLoad   = (op == I_ALU) && (f3 == 3'b010);
      isBranch = (op == BRANCH);
      trap     = 1'b0;
      if (atIdle) begin
         repeat ($urandom_range(0, 2))
            pushCycle(0, 7'($urandom), 3'($urandom), rnd(), rnd(), expOut(0, 0, 0, 0, 0, 0, 0, 0));
         pushCycle(1, 7'($urandom), 3'($urandom), rnd(), rnd(), expOut(0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int k = 0; k < T; k++) begin
         if (k == imDelay) begin
            pushCycle(rnd(), op, f3, 1, rnd(), expOut(1, 1, 0, 0, 1, 0, 0, 0));
            break;
         end
         pushCycle(rnd(), op, f3, 0, rnd(), expOut(1, 1, 0, 0, 0, 0, 0, 0));
      end
      if (imDelay >= T) begin
         addTrap(6);
         trap = 1'b1;
         return;
      end
      pushCycle(rnd(), op, f3, rnd(), rnd(), expOut(2, 0, 0, 0, 0, 0, 0, 0));
      if (!legal) begin
         addTrap(6);
         trap = 1'b1;
         return;
      end
      pushCycle(rnd(), op, f3, rnd(), rnd(), expOut(3, 0, 0, 0, 0, 0, 0, 0));
      if (isStore || isLoad) begin
         for (int k = 0; k < T; k++) begin
            if (k == dmDelay) begin
               pushCycle(rnd(), op, f3, rnd(), 1, expOut(4, 0, 1, int'(isStore), 0, 0, 0, 0));
               break;
            end
            pushCycle(rnd(), op, f3, rnd(), 0, expOut(4, 0, 1, int'(isStore), 0, 0, 0, 0));
         end
         if (dmDelay >= T) begin
            addTrap(6);
            trap = 1'b1;
            return;
         end
      end
      pushCycle(enWb, op, f3, rnd(), rnd(),
                expOut(5, 0, 0, 0, 0, int'(!(isStore || isBranch)), 1, 0));
      atIdle = (enWb == 0);
   endtask

   task automatic applyStimulus(input cycle_t c);
      @(negedge CLK);
      EN      = 1'(c.en);
      OP_CODE = c.op;
      FUNCT_3 = c.f3;
      IM_ACK  = 1'(c.im_ack);
      DM_ACK  = 1'(c.dm_ack);
      #1;
   endtask

   task automatic playPlan();
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         checkOutput($sformatf("%s[%0d]", section, i), 32'(observed), 32'(plan[i].expect_v));
      end
      plan.delete();
   endtask

   // Asserts reset between clock edges, checks it acts at once, then releases.
   task automatic resetDut(input string tag);
      @(negedge CLK);
      EN = 1'b0; IM_ACK = 1'b0; DM_ACK = 1'b0;
      #2 RST_N = 1'b0;
      #1 checkOutput({tag, "_async"}, 32'(observed), 32'd0);
      @(negedge CLK);
      #1 checkOutput({tag, "_held"}, 32'(observed), 32'd0);
      RST_N  = 1'b1;
      atIdle = 1'b1;
   endtask

   initial begin
      logic [6:0] opTab [8];
      opTab[0] = I_ALU; opTab[1] = R_ALU; opTab[2] = STORE; opTab[3] = LUI;
      opTab[4] = BRANCH; opTab[5] = JAL; opTab[6] = JALR; opTab[7] = 7'b0000011;

      RST_N = 1'b0; EN = 1'b0; OP_CODE = '0; FUNCT_3 = '0; IM_ACK = 1'b0; DM_ACK = 1'b0;
      #3 checkOutput("reset_state", 32'(observed), 32'd0);
`ifdef SEQ_PERF_CNT_EN
      checkOutput("reset_cyc", CYC_CNT, 32'd0);
      checkOutput("reset_ret", RET_CNT, 32'd0);
`endif
      @(negedge CLK);
      RST_N  = 1'b1;
      atIdle = 1'b1;

      section = "addi";
      addInstr(I_ALU, 3'b000, 2, 0, 0, trapped);
      playPlan();

      section = "sw_bne_lw";
      addInstr(STORE, 3'b010, 0, 2, 1, trapped);
      addInstr(BRANCH, 3'b001, 0, 0, 1, trapped);
      addInstr(I_ALU, 3'b010, 1, 1, 0, trapped);
      playPlan();

      section = "im_ack_last";
      addInstr(LUI, 3'b000, T - 1, 0, 0, trapped);
      playPlan();

      section = "im_timeout";
      addInstr(R_ALU, 3'b000, T, 0, 0, trapped);
      playPlan();
      resetDut("rst_im_tmo");

      section = "dm_timeout";
      addInstr(STORE, 3'b000, 0, T, 0, trapped);
      playPlan();
      resetDut("rst_dm_tmo");

      section = "illegal";
      addInstr(7'b0000000, 3'b000, 1, 0, 0, trapped);
      addTrap(14);
      playPlan();
      resetDut("rst_illegal");

      // Reset landing in the middle of a store's MEM phase.
      section = "rst_mem";
      addInstr(STORE, 3'b000, 0, T, 0, trapped);
      for (int i = 0; i < plan.size(); i++) begin
         if (plan[i].expect_v[9:7] == 3'd4) begin
            while (plan.size() > i) void'(plan.pop_back());
            break;
         end
      end
      playPlan();
      @(negedge CLK);
      EN = 1'b0; IM_ACK = 1'b0; DM_ACK = 1'b0;
      #1 checkOutput("rst_mem_pre", 32'(observed), 32'(expOut(4, 0, 1, 1, 0, 0, 0, 0)));
      #2 RST_N = 1'b0;
      #1 checkOutput("rst_mem_async", 32'(observed), 32'd0);
      @(negedge CLK);
      RST_N  = 1'b1;
      atIdle = 1'b1;
      section = "after_rst";
      addInstr(JAL, 3'b000, 0, 0, 0, trapped);
      playPlan();

      for (int n = 0; n < 40; n++) begin
         logic [6:0] op;
         int imD, dmD;
         op  = opTab[$urandom_range(0, 7)];
         imD = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, T - 1));
         dmD = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, T - 1));
         section = $sformatf("rand%0d", n);
         addInstr(op, ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom), imD, dmD, rnd(), trapped);
         playPlan();
         if (trapped) resetDut($sformatf("rst_rand%0d", n));
      end

`ifdef SEQ_PERF_CNT_EN
      resetDut("rst_perf");
      section = "perf";
      for (int i = 0; i < 10; i++) addInstr(BRANCH, 3'b001, 0, 0, (i < 9) ? 1 : 0, trapped);
      playPlan();
      @(negedge CLK);
      EN = 1'b0;
      #1;
      checkOutput("ret_cnt", RET_CNT, 32'd10);
      checkOutput("cyc_cnt", CYC_CNT, 32'd40);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum wait cycles for an IM_ACK or DM_ACK before trapping (range 1..255).
REQ-002 Port: CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: RST_N  in  1  reset, asynchronous and active-low.
REQ-004 Port: EN  in  1  run enable; when low, no new fetch is issued.
REQ-005 Port: OP_CODE  in  7  opcode of the instruction register contents.
REQ-006 Port: FUNCT_3  in  3  funct3 of the instruction register contents.
REQ-007 Port: IM_ACK  in  1  instruction memory data valid; 1-cycle pulse.
REQ-008 Port: DM_ACK  in  1  data memory done; 1-cycle pulse.
REQ-009 Ports, 1 bit each, out: IM_REQ (instruction request), DM_REQ (data request), DM_WE (data write qualifier), IR_WE (instruction register load), RF_WE (register file write), PC_WE (program counter update), ERR (sticky trap flag).
REQ-010 Port: STATE  out  3  current FSM state encoding, for debug.

Function
REQ-011 The FSM SHALL have these states and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-012 IDLE SHALL move to FETCH when EN=1 and SHALL otherwise stay in IDLE.
REQ-013 FETCH SHALL hold IM_REQ=1 until IM_ACK, then pulse IR_WE=1 in the ack cycle and move to DECODE.
REQ-014 DECODE SHALL last one cycle; legal opcodes go to EXEC and any other opcode goes to TRAP.
- Legal opcodes: 0010011, 0110011, 0100011, 0110111, 1100011, 1101111, 1100111.
REQ-015 EXEC SHALL last one cycle.
- Load (OP_CODE=0010011 with FUNCT_3=010) and store (0100011) go to MEM.
- All other legal opcodes go to WB.
REQ-016 MEM SHALL hold DM_REQ=1 until DM_ACK, with DM_WE=1 throughout for stores and 0 for loads, then move to WB.
REQ-017 WB SHALL pulse PC_WE=1 for exactly one cycle.
- It SHALL also pulse RF_WE=1 for every class except store (0100011) and branch (1100011).
REQ-018 From WB the FSM SHALL go to FETCH if EN=1, else to IDLE.
REQ-019 A wait counter (8 bits) SHALL clear on entry to FETCH or MEM and increment each cycle without ack.
- When it reaches MEM_TIMEOUT without an ack, the FSM SHALL go to TRAP.
- An ack arriving in that same cycle wins over the timeout.
REQ-020 In TRAP, ERR=1, all request and write-enable outputs are 0, and the FSM stays there until reset.
REQ-021 IM_ACK outside FETCH and DM_ACK outside MEM SHALL be ignored.
REQ-022 EN deassertion mid-instruction SHALL NOT abort it; it is honoured only in IDLE and WB.
REQ-023 Outputs SHALL be registered or decoded from registered state only, with no combinational path from any ack to a REQ output.

Reset
REQ-024 With RST_N=0, the FSM SHALL be forced to IDLE and the wait counter to 0, and all outputs SHALL read 0, immediately and independent of CLK.
REQ-025 Reset asserted mid-MEM SHALL drop DM_REQ and DM_WE asynchronously, with no write pulse completed.

Configuration
REQ-026 With macro SEQ_PERF_CNT_EN defined, two extra outputs SHALL exist:
- CYC_CNT[31:0]: counts every cycle outside IDLE and TRAP.
- RET_CNT[31:0]: increments on each WB cycle.
- Both wrap at 2^32 and clear on reset.
REQ-027 With SEQ_PERF_CNT_EN undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the following, reused by the decoder and the datapath:
- the state encodings;
- the opcode constants (OP_IALU, OP_R, OP_S, OP_LUI, OP_B, OP_JAL, OP_JALR);
- the load FUNCT_3 constant 010.
REQ-029 One sub-module, seq_wait_timer, SHALL implement the wait counter and timeout compare; the FSM lives in the top.

Verification
REQ-030 ADDI with EN=1 and IM_ACK 2 cycles after IM_REQ -> path FETCH,FETCH,FETCH,DECODE,EXEC,WB; RF_WE and PC_WE are 1 only in WB; 6 cycles per instruction.
REQ-031 SW with DM_ACK after 3 cycles -> DM_REQ=DM_WE=1 for 3 cycles, RF_WE stays 0, PC_WE pulses once.
REQ-032 OP_CODE=0000000 -> TRAP after DECODE, ERR=1, and the FSM stays in TRAP over 20 cycles with EN toggling.
REQ-033 MEM_TIMEOUT=4 and no IM_ACK -> TRAP after exactly 4 wait cycles; IM_ACK on the 4th cycle -> DECODE instead.
REQ-034 RST_N pulled low mid-MEM between clock edges -> DM_REQ=0 and STATE=0 before the next edge; after release with EN=1, FETCH follows.
REQ-035 Under SEQ_PERF_CNT_EN, 10 BNE instructions with zero wait states -> RET_CNT=10 and CYC_CNT=40.
